bist_run_sequencer: RTL and testbench

Host-side initiator for the BIST controller. It owns the test session: asserts testmode, clears the TPG/MISR, waits for pattern completion, captures the MISR signature and compares it with the golden value. It repeats the run MAX_RUNS times to catch intermittent faults, then reports pass/fail to system logic through a start/done handshake.

---
 rtl/bist_run_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_bist_run_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_run_sequencer.sv
// BIST session initiator: clears the TPG/MISR, waits for pattern completion,
// captures and compares the signature over MAX_RUNS runs, then reports pass/fail.
module bist_run_sequencer #(
    parameter int unsigned            SIG_WIDTH      = 4,
    parameter logic [SIG_WIDTH-1:0]   GOLDEN_SIG     = SIG_WIDTH'(4'b0011),
    parameter int unsigned            PATTERN_COUNT  = 7,
    parameter int unsigned            TIMEOUT_MARGIN = 4,
    parameter int unsigned            MAX_RUNS       = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 complete_in,
    input  logic [SIG_WIDTH-1:0] signature_in,
    output logic                 testmode,
    output logic                 sub_clear,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic                 aborted,
    output logic [3:0]           run_count,
    output logic [SIG_WIDTH-1:0] captured_sig
);

    localparam int unsigned RUN_LIMIT = PATTERN_COUNT + TIMEOUT_MARGIN;
    localparam int unsigned CNT_W     = $clog2(RUN_LIMIT + 1);
    localparam int unsigned RC_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_COMPARE,
        S_REPORT
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic                 r_mismatch,  w_mismatch_nxt;
    logic                 r_timeout,   w_timeout_nxt;
    logic                 r_aborted,   w_aborted_nxt;
    logic                 r_pass,      w_pass_nxt;
    logic                 r_fail,      w_fail_nxt;
    logic [RC_W-1:0]      r_run_count, w_run_count_nxt;
    logic [SIG_WIDTH-1:0] r_captured,  w_captured_nxt;
    logic                 r_testmode,  w_testmode_nxt;
    logic                 r_sub_clear, w_sub_clear_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic                 r_done,      w_done_nxt;

    logic [CNT_W-1:0]     w_cnt_inc;
    logic [RC_W-1:0]      w_run_count_inc;

    assign w_cnt_inc       = CNT_W'(r_cnt + 1'b1);
    assign w_run_count_inc = RC_W'(r_run_count + 1'b1);

    // State and all outputs are registered together so outputs track the state they belong to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mismatch  <= 1'b0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_run_count <= '0;
            r_captured  <= '0;
            r_testmode  <= 1'b0;
            r_sub_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mismatch  <= w_mismatch_nxt;
            r_timeout   <= w_timeout_nxt;
            r_aborted   <= w_aborted_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_run_count <= w_run_count_nxt;
            r_captured  <= w_captured_nxt;
            r_testmode  <= w_testmode_nxt;
            r_sub_clear <= w_sub_clear_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mismatch_nxt  = r_mismatch;
        w_timeout_nxt   = r_timeout;
        w_aborted_nxt   = r_aborted;
        w_pass_nxt      = r_pass;
        w_fail_nxt      = r_fail;
        w_run_count_nxt = r_run_count;
        w_captured_nxt  = r_captured;
        w_testmode_nxt  = 1'b0;
        w_sub_clear_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_pass_nxt      = 1'b0;
                    w_fail_nxt      = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_aborted_nxt   = 1'b0;
                    w_run_count_nxt = '0;
                    w_mismatch_nxt  = 1'b0;
                    w_state_nxt     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (complete_in) begin
                    w_state_nxt = S_CAPTURE;
                end else if (w_cnt_inc == CNT_W'(RUN_LIMIT)) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_REPORT;
                end
            end
            S_CAPTURE: begin
                w_captured_nxt = signature_in;
                w_state_nxt    = S_COMPARE;
            end
            S_COMPARE: begin
                if (r_captured != GOLDEN_SIG) begin
                    w_mismatch_nxt = 1'b1;
                end
                w_run_count_nxt = w_run_count_inc;
                w_state_nxt     = (w_run_count_inc == RC_W'(MAX_RUNS)) ? S_REPORT : S_CLEAR;
            end
            S_REPORT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides any progress made this cycle; counters keep their last values.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = r_cnt;
            w_mismatch_nxt  = r_mismatch;
            w_timeout_nxt   = r_timeout;
            w_run_count_nxt = r_run_count;
            w_captured_nxt  = r_captured;
            w_pass_nxt      = 1'b0;
            w_fail_nxt      = 1'b0;
            w_aborted_nxt   = 1'b1;
        end

        w_testmode_nxt  = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_RUN) ||
                          (w_state_nxt == S_CAPTURE) || (w_state_nxt == S_COMPARE);
        w_sub_clear_nxt = (w_state_nxt == S_CLEAR);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_REPORT);

        if (w_state_nxt == S_REPORT) begin
            w_pass_nxt = !w_mismatch_nxt && !w_timeout_nxt;
            w_fail_nxt = w_mismatch_nxt || w_timeout_nxt;
        end
    end

    assign testmode     = r_testmode;
    assign sub_clear    = r_sub_clear;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign timeout      = r_timeout;
    assign aborted      = r_aborted;
    assign run_count    = r_run_count;
    assign captured_sig = r_captured;

endmodule

// File: tb/tb_bist_run_sequencer.sv
// Randomized session-level bench for bist_run_sequencer; expectations come from a
// per-session schedule model (run lengths, signatures, abort point).
module tb_bist_run_sequencer;

    localparam logic [3:0]  GOLD  = 4'b0011;
    localparam int unsigned NRUN  = 3;
    localparam int unsigned LIMIT = 11;
    localparam int unsigned MAXC  = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       complete_in = 1'b0;
    logic [3:0] signature_in = 4'd0;
    logic       testmode, sub_clear, busy, done, pass, fail, timeout, aborted;
    logic [3:0] run_count;
    logic [3:0] captured_sig;

    bist_run_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .complete_in  (complete_in),
        .signature_in (signature_in),
        .testmode     (testmode),
        .sub_clear    (sub_clear),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .aborted      (aborted),
        .run_count    (run_count),
        .captured_sig (captured_sig)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Session plan: per-run completion cycle (0 = never completes) and signature.
    int         plan_k   [NRUN];
    logic [3:0] plan_sig [NRUN];

    // Derived schedule (cycle 1 is the first cycle after the start edge).
    bit         cin_s [MAXC];
    logic [3:0] sig_s [MAXC];
    int         clear_cyc [NRUN];
    int         cap_cyc   [NRUN];
    int         cmp_cyc   [NRUN];
    int         n_started;
    int         sess_len;

    // Values the outputs should hold between sessions.
    logic       m_pass = 0, m_fail = 0, m_timeout = 0, m_aborted = 0;
    logic [3:0] m_run_count = 0;
    logic [3:0] m_captured  = 0;

    function automatic void build_schedule();
        int c = 1;
        n_started = 0;
        for (int i = 0; i < MAXC; i++) begin
            cin_s[i] = 1'($urandom_range(0, 1));
            sig_s[i] = 4'($urandom);
        end
        for (int r = 0; r < NRUN; r++) begin
            clear_cyc[r] = c;
            cap_cyc[r]   = MAXC;
            cmp_cyc[r]   = MAXC;
            n_started    = r + 1;
            if (plan_k[r] == 0) begin
                for (int j = 1; j <= LIMIT; j++) cin_s[c + j] = 1'b0;
                c = c + 1 + LIMIT;
                break;
            end
            for (int j = 1; j <= plan_k[r]; j++) cin_s[c + j] = (j == plan_k[r]);
            cap_cyc[r] = c + 1 + plan_k[r];
            cmp_cyc[r] = cap_cyc[r] + 1;
            sig_s[cap_cyc[r]] = plan_sig[r];
            c = cmp_cyc[r] + 1;
        end
        sess_len = c;
    endfunction

    // Drive one session (abort_at = 0 means no abort) and check its outcome.
    task automatic run_session(input int abort_at);
        int         last, runs, clears, n_done, done_at, n_sc, n_tm, n_busy;
        logic       mm, to, e_pass;
        logic [3:0] e_cap;
        last  = (abort_at != 0) ? abort_at : sess_len;
        runs  = 0; clears = 0; mm = 0; to = 0; e_cap = m_captured;
        for (int r = 0; r < n_started; r++) begin
            if (clear_cyc[r] <= last) clears++;
            if (plan_k[r] == 0) begin
                to = (abort_at == 0);
            end else begin
                if (cap_cyc[r] < last || abort_at == 0) e_cap = plan_sig[r];
                if (cmp_cyc[r] < last || abort_at == 0) begin
                    runs++;
                    if (plan_sig[r] != GOLD) mm = 1;
                end
            end
        end
        e_pass = !mm && !to;

        n_done = 0; done_at = -1; n_sc = 0; n_tm = 0; n_busy = 0;
        @(negedge clock);
        start = 1'b1; abort = 1'b0; complete_in = 1'b0; signature_in = 4'($urandom);
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clock);
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            n_sc   += int'(sub_clear);
            n_tm   += int'(testmode);
            n_busy += int'(busy);
            if (c == 1) begin
                check("start_clears", 32'({pass, fail, timeout, aborted, run_count}), 32'd0);
            end
            if (c == last + 1) begin
                check("end_idle",   32'({busy, testmode}), 32'd0);
                check("pass",       32'(pass),    32'(abort_at == 0 && e_pass));
                check("fail",       32'(fail),    32'(abort_at == 0 && !e_pass));
                check("timeout",    32'(timeout), 32'(to));
                check("aborted",    32'(aborted), 32'(abort_at != 0));
                check("run_count",  32'(run_count), 32'(runs));
                check("captured",   32'(captured_sig), 32'(e_cap));
            end
            start        = (c <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
            abort        = (c == abort_at);
            complete_in  = cin_s[c];
            signature_in = sig_s[c];
        end
        start = 1'b0; abort = 1'b0;
        check("done_pulses", 32'(n_done), 32'(abort_at == 0));
        if (abort_at == 0) check("done_latency", 32'(done_at), 32'(sess_len));
        check("sub_clear_cnt", 32'(n_sc),   32'(clears));
        check("testmode_cnt",  32'(n_tm),   32'((abort_at == 0) ? sess_len - 1 : abort_at));
        check("busy_cnt",      32'(n_busy), 32'(last));

        m_pass      = (abort_at == 0) && e_pass;
        m_fail      = (abort_at == 0) && !e_pass;
        m_timeout   = to;
        m_aborted   = (abort_at != 0);
        m_run_count = 4'(runs);
        m_captured  = e_cap;
    endtask

    // Start and abort together in IDLE must leave everything untouched.
    task automatic idle_start_abort();
        @(negedge clock);
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 32'({busy, testmode, sub_clear}), 32'd0);
        check("sa_held", 32'({pass, fail, timeout, aborted, run_count, captured_sig}),
              32'({m_pass, m_fail, m_timeout, m_aborted, m_run_count, m_captured}));
        @(negedge clock);
        check("sa_stay_idle", 32'(busy), 32'd0);
    endtask

    task automatic set_plan(input int k0, input int k1, input int k2,
                            input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2);
        plan_k[0] = k0;   plan_k[1] = k1;   plan_k[2] = k2;
        plan_sig[0] = s0; plan_sig[1] = s1; plan_sig[2] = s2;
        build_schedule();
    endtask

    initial begin
        int idle_busy;
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'({testmode, sub_clear, busy, done, pass, fail, timeout,
                                    aborted, run_count, captured_sig}), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        set_plan(7, 7, 7, GOLD, GOLD, GOLD);
        run_session(0);
        idle_start_abort();
        set_plan(7, 7, 7, GOLD, 4'b0110, GOLD);
        run_session(0);
        set_plan(0, 0, 0, GOLD, GOLD, GOLD);
        run_session(0);
        set_plan(7, 7, 7, GOLD, GOLD, GOLD);
        run_session(14);
        idle_start_abort();
        run_session(0);
        set_plan(11, 1, 11, GOLD, GOLD, GOLD);
        run_session(0);

        for (int s = 0; s < 40; s++) begin
            for (int r = 0; r < NRUN; r++) begin
                plan_k[r]   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, LIMIT));
                plan_sig[r] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : GOLD;
            end
            build_schedule();
            run_session(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, sess_len - 1)) : 0);
        end

        // Asynchronous reset during the first COMPARE cycle.
        set_plan(5, 7, 7, GOLD, GOLD, GOLD);
        @(negedge clock);
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c < 8) begin
                complete_in  = cin_s[c];
                signature_in = sig_s[c];
            end
        end
        check("pre_reset_active", 32'({busy, testmode, captured_sig}), 32'({2'b11, GOLD}));
        reset = 1'b0;
        #1;
        check("async_reset", 32'({testmode, sub_clear, busy, done, pass, fail, timeout,
                                  aborted, run_count, captured_sig}), 32'd0);
        complete_in = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        m_pass = 0; m_fail = 0; m_timeout = 0; m_aborted = 0; m_run_count = 0; m_captured = 0;
        idle_busy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            complete_in = 1'($urandom_range(0, 1));
            idle_busy += int'(busy);
        end
        complete_in = 1'b0;
        check("post_reset_idle", 32'(idle_busy), 32'd0);
        set_plan(7, 7, 7, GOLD, GOLD, GOLD);
        run_session(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
